led_driver_rx: RTL and testbench

- Bus-functional receiver for the LED-driver serial interface: the device side of the serial/sclk/lat/gsclk link driven by the controller.
- Shifts in grayscale frames on sclk and latches them on lat.
- Runs a grayscale counter on gsclk and produces per-channel PWM outputs.
- Used as the on-chip loopback target and the self-checking model in controller benches; all logic runs on the single system clock.

---
 rtl/led_driver_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_led_driver_rx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_driver_rx.sv
// ----------------------------------------------------------------------------
// led_driver_rx
//
// Device side of the LED-driver serial link (serial/sclk/lat/gsclk). Grayscale
// frames are shifted in MSB first on sclk rising edges and copied into a latch
// register on lat rising edges. A saturating grayscale counter advances on
// gsclk rising edges and each channel's PWM output is high while the counter
// is below that channel's latched value. Every link input is sampled on the
// single system clock through a synchroniser chain.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   serial       serial data, MSB first
//   sclk         shift clock
//   lat          latch strobe
//   gsclk        grayscale clock
//   blank        high clears the GS counter and forces all PWM low
//   sout         MSB of the shift register (daisy-chain out)
//   pwm_out      per-channel PWM, active-high
//   frame_valid  one-cycle pulse after a latch
//   frame_error  valid with frame_valid: latched bit count was not a full frame
//   rx_state     0 IDLE, 1 SHIFTING, 2 FULL, 3 OVERRUN
// ----------------------------------------------------------------------------
module led_driver_rx #(
    parameter int unsigned CHANNELS    = 16,
    parameter int unsigned GS_BITS     = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial,
    input  logic                sclk,
    input  logic                lat,
    input  logic                gsclk,
    input  logic                blank,
    output logic                sout,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_valid,
    output logic                frame_error,
    output logic [1:0]          rx_state
);

    localparam int unsigned TOTAL   = CHANNELS * GS_BITS;
    localparam int unsigned CNT_W   = $clog2(TOTAL + 2);
    // Never fewer than two flops, whatever the caller asks for.
    localparam int unsigned SYNC_ST = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [CNT_W-1:0]   CntFull = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]   CntSat  = CNT_W'(TOTAL + 1);
    localparam logic [GS_BITS-1:0] GsMax   = '1;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StShifting = 2'd1,
        StFull     = 2'd2,
        StOverrun  = 2'd3
    } rx_state_e;

    // ------------------------------------------------------------------
    // Synchronisers and rising-edge detection.
    // Bit order inside each stage: {serial, sclk, lat, gsclk}.
    // ------------------------------------------------------------------
    logic [3:0] sync_q [SYNC_ST];
    logic [2:0] prev_q;      // previous synced {sclk, lat, gsclk}
    logic [3:0] sync_s;
    logic       serial_s;
    logic       sclk_rise;
    logic       lat_rise;
    logic       gsclk_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_ST; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= {serial, sclk, lat, gsclk};
            for (int i = 1; i < SYNC_ST; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_s[2:0];
        end
    end

    assign sync_s     = sync_q[SYNC_ST-1];
    assign serial_s   = sync_s[3];
    assign sclk_rise  = sync_s[2] & ~prev_q[2];
    assign lat_rise   = sync_s[1] & ~prev_q[1];
    assign gsclk_rise = sync_s[0] & ~prev_q[0];

    // ------------------------------------------------------------------
    // Shift register, latch register and bit counter.
    // ------------------------------------------------------------------
    logic [TOTAL-1:0] shift_q, shift_d;
    logic [TOTAL-1:0] latch_q, latch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        latch_d = latch_q;
        cnt_d   = cnt_q;

        if (sclk_rise) begin
            shift_d = {shift_q[TOTAL-2:0], serial_s};
        end

        // The latch takes the pre-shift contents when both edges coincide.
        if (lat_rise) begin
            latch_d = shift_q;
        end

        if (lat_rise) begin
            // A coincident shift is the first bit of the next frame.
            cnt_d = sclk_rise ? CNT_W'(1) : '0;
        end else if (sclk_rise && (cnt_q != CntSat)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            latch_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sout = shift_q[TOTAL-1];

    // ------------------------------------------------------------------
    // Frame state: a registered decode of the bit counter, so state_q always
    // describes cnt_q.
    // ------------------------------------------------------------------
    rx_state_e state_q, state_d;

    always_comb begin
        state_d = StIdle;
        if (cnt_d == '0) begin
            state_d = StIdle;
        end else if (cnt_d < CntFull) begin
            state_d = StShifting;
        end else if (cnt_d == CntFull) begin
            state_d = StFull;
        end else begin
            state_d = StOverrun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign rx_state = state_q;

    // ------------------------------------------------------------------
    // Frame status pulse, judged on the state before this cycle's shift.
    // ------------------------------------------------------------------
    logic frame_valid_q;
    logic frame_error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            frame_valid_q <= lat_rise;
            frame_error_q <= lat_rise && (state_q != StFull);
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;

    // ------------------------------------------------------------------
    // Grayscale counter: saturating, held at zero while blanked.
    // ------------------------------------------------------------------
    logic [GS_BITS-1:0] gs_q, gs_d;

    always_comb begin
        gs_d = gs_q;
        if (blank) begin
            gs_d = '0;
        end else if (gsclk_rise && (gs_q != GsMax)) begin
            gs_d = gs_q + GS_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gs_q <= '0;
        end else begin
            gs_q <= gs_d;
        end
    end

    // ------------------------------------------------------------------
    // PWM: compares registered counter and latch, so outputs follow either
    // one clock later. Strict less-than keeps a zero value permanently off.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = !blank && (gs_q < latch_q[i*GS_BITS +: GS_BITS]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_led_driver_rx.sv
// ----------------------------------------------------------------------------
// tb_led_driver_rx
//
// Directed stimulus for led_driver_rx. A behavioural model (bit queue, integer
// channel values, integer GS counter) predicts every registered output and is
// compared on every clock; hand-computed literal checks pin the model and the
// scenarios of interest.
// ----------------------------------------------------------------------------
module tb_led_driver_rx;

    localparam int CH    = 16;
    localparam int GB    = 12;
    localparam int SS    = 2;
    localparam int TOTAL = CH * GB;
    localparam int GMAX  = (1 << GB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial;
    logic          sclk;
    logic          lat;
    logic          gsclk;
    logic          blank;
    logic          sout;
    logic [CH-1:0] pwm_out;
    logic          frame_valid;
    logic          frame_error;
    logic [1:0]    rx_state;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    led_driver_rx #(
        .CHANNELS    (CH),
        .GS_BITS     (GB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .serial      (serial),
        .sclk        (sclk),
        .lat         (lat),
        .gsclk       (gsclk),
        .blank       (blank),
        .sout        (sout),
        .pwm_out     (pwm_out),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .rx_state    (rx_state)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit            m_sr[$];          // index 0 = oldest bit = MSB
    int            m_cnt;
    int            m_lat[CH];
    int            m_gs;
    bit            m_fv;
    bit            m_fe;
    logic [CH-1:0] m_pwm;
    // Input samples per clock, index 0 newest. An edge is seen SS clocks late.
    bit            h_ser[SS+2];
    bit            h_sck[SS+2];
    bit            h_lat[SS+2];
    bit            h_gs[SS+2];

    task automatic m_reset();
        m_sr.delete();
        repeat (TOTAL) m_sr.push_back(1'b0);
        m_cnt = 0;
        m_gs  = 0;
        m_fv  = 1'b0;
        m_fe  = 1'b0;
        m_pwm = '0;
        for (int c = 0; c < CH; c++) m_lat[c] = 0;
        for (int i = 0; i < SS + 2; i++) begin
            h_ser[i] = 1'b0;
            h_sck[i] = 1'b0;
            h_lat[i] = 1'b0;
            h_gs[i]  = 1'b0;
        end
    endtask

    task automatic m_step();
        bit se, le, ge, sb;
        int v;
        for (int i = SS + 1; i > 0; i--) begin
            h_ser[i] = h_ser[i-1];
            h_sck[i] = h_sck[i-1];
            h_lat[i] = h_lat[i-1];
            h_gs[i]  = h_gs[i-1];
        end
        h_ser[0] = serial;
        h_sck[0] = sclk;
        h_lat[0] = lat;
        h_gs[0]  = gsclk;
        se = h_sck[SS] && !h_sck[SS+1];
        le = h_lat[SS] && !h_lat[SS+1];
        ge = h_gs[SS]  && !h_gs[SS+1];
        sb = h_ser[SS];

        for (int c = 0; c < CH; c++) m_pwm[c] = !blank && (m_gs < m_lat[c]);
        m_fv = le;
        m_fe = le && (m_cnt != TOTAL);
        if (le) begin
            for (int c = 0; c < CH; c++) begin
                v = 0;
                for (int j = 0; j < GB; j++) v = v * 2 + int'(m_sr[(CH - 1 - c) * GB + j]);
                m_lat[c] = v;
            end
        end
        if (se) begin
            m_sr.push_back(sb);
            void'(m_sr.pop_front());
        end
        if (le)                           m_cnt = se ? 1 : 0;
        else if (se && m_cnt < TOTAL + 1) m_cnt = m_cnt + 1;
        if (blank)                  m_gs = 0;
        else if (ge && m_gs < GMAX) m_gs = m_gs + 1;
    endtask

    function automatic logic [1:0] m_state();
        if (m_cnt == 0)     return 2'd0;
        if (m_cnt < TOTAL)  return 2'd1;
        if (m_cnt == TOTAL) return 2'd2;
        return 2'd3;
    endfunction

    // Per-cycle compare, 1 time unit after the active edge.
    initial begin
        logic [20:0] act, expv;
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) m_reset();
            else     m_step();
            #1;
            act  = {rx_state, sout, frame_valid, frame_error, pwm_out};
            expv = {m_state(), m_sr[0], m_fv, m_fe, m_pwm};
            n_vec++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got state=%0d sout=%b fv=%b fe=%b pwm=%h, expected state=%0d sout=%b fv=%b fe=%b pwm=%h",
                         $time, act[20:19], act[18], act[17], act[16], act[15:0],
                         expv[20:19], expv[18], expv[17], expv[16], expv[15:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        tick(SS + 3);
    endtask

    task automatic send_bit(input bit b);
        serial = b;
        sclk   = 1'b1;
        tick(1);
        sclk   = 1'b0;
        tick(1);
    endtask

    task automatic send_vec(input logic [TOTAL-1:0] v);
        for (int i = TOTAL - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic gs_pulses(input int n);
        repeat (n) begin
            gsclk = 1'b1;
            tick(1);
            gsclk = 1'b0;
            tick(1);
        end
    endtask

    // Raise lat (optionally with sclk), then wait a bounded time for the pulse.
    task automatic latch_frame(input string name, input bit with_sclk, input bit exp_err);
        bit got = 1'b0;
        bit e   = 1'b0;
        serial = 1'b1;
        sclk   = with_sclk;
        lat    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            lat  = 1'b0;
            sclk = 1'b0;
            if (frame_valid && !got) begin
                got = 1'b1;
                e   = frame_error;
            end
        end
        check({name, " frame_valid seen"}, 256'(got), 256'(1));
        check({name, " frame_error"}, 256'(e), 256'(exp_err));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [TOTAL-1:0] f_full, p_long, q_sim;
        f_full = '0;
        f_full[TOTAL-1 -: GB] = 12'hFFF;
        f_full[TOTAL-1-GB -: GB] = 12'h800;
        p_long = '0;
        p_long[GB-1:0] = 12'h400;
        p_long[3*GB +: GB] = 12'hABC;
        p_long[TOTAL-1 -: GB] = 12'h5F3;
        q_sim = '0;
        q_sim[GB-1:0] = 12'h400;
        q_sim[7*GB +: GB] = 12'h5A5;
        q_sim[TOTAL-1 -: GB] = 12'h123;

        rst = 1'b1; serial = 1'b0; sclk = 1'b0; lat = 1'b0; gsclk = 1'b0; blank = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset rx_state", 256'(rx_state), 256'(0));
        check("reset pwm_out", 256'(pwm_out), 256'(0));
        check("reset frame_valid", 256'(frame_valid), 256'(0));

        // Reset mid-frame after 100 bits.
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(1)));
        settle();
        check("100 bits rx_state", 256'(rx_state), 256'(1));
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("midframe reset rx_state", 256'(rx_state), 256'(0));
        check("midframe reset latch", 256'(dut.latch_q), 256'(0));
        check("midframe reset sout", 256'(sout), 256'(0));
        latch_frame("lat after reset", 1'b0, 1'b1);

        // Full frame.
        send_vec(f_full);
        settle();
        check("full rx_state", 256'(rx_state), 256'(2));
        latch_frame("full frame", 1'b0, 1'b0);
        check("full latch ch15", 256'(dut.latch_q[15*GB +: GB]), 256'(12'hFFF));
        check("full latch ch14", 256'(dut.latch_q[14*GB +: GB]), 256'(12'h800));
        check("model latch ch15", 256'(m_lat[15]), 256'(12'hFFF));
        check("model latch ch14", 256'(m_lat[14]), 256'(12'h800));
        check("after lat rx_state", 256'(rx_state), 256'(0));

        // PWM sweep.
        gs_pulses(2047);
        settle();
        check("pwm at 2047", 256'(pwm_out), 256'(16'hC000));
        gs_pulses(1);
        settle();
        check("pwm at 2048", 256'(pwm_out), 256'(16'h8000));
        gs_pulses(2047);
        settle();
        check("pwm at 4095", 256'(pwm_out), 256'(0));
        check("model gs saturated", 256'(m_gs), 256'(4095));
        gs_pulses(3);
        settle();
        check("pwm after saturation", 256'(pwm_out), 256'(0));

        // Short frame.
        for (int i = 0; i < TOTAL - 1; i++) send_bit(1'(i % 3 == 0));
        settle();
        check("191 bits rx_state", 256'(rx_state), 256'(1));
        latch_frame("short frame", 1'b0, 1'b1);

        // Long frame: 8 leading ones fall out of the MSB.
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_vec(p_long);
        settle();
        check("200 bits rx_state", 256'(rx_state), 256'(3));
        latch_frame("long frame", 1'b0, 1'b1);
        check("long frame latch", 256'(dut.latch_q), 256'(p_long));

        // Coincident sclk and lat edges after exactly one frame.
        send_vec(q_sim);
        settle();
        latch_frame("simultaneous", 1'b1, 1'b0);
        check("simultaneous latch", 256'(dut.latch_q), 256'(q_sim));
        check("simultaneous rx_state", 256'(rx_state), 256'(1));

        // Blank.
        blank = 1'b1;
        tick(1);
        blank = 1'b0;
        gs_pulses(1000);
        settle();
        check("pwm ch0 at 1000", 256'(pwm_out[0]), 256'(1));
        blank = 1'b1;
        tick(1);
        check("blank forces pwm low", 256'(pwm_out), 256'(0));
        tick(3);
        blank = 1'b0;
        tick(1);
        check("unblank pwm ch0", 256'(pwm_out[0]), 256'(1));
        check("unblank pwm", 256'(pwm_out), 256'(16'h8081));

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
